// File: rtl/imem_loader_if.sv
// Byte-stream and instruction-memory write bus used by the program loader.
// The loader sits on the slave side: it consumes the byte stream and drives
// the memory write port. The master side feeds bytes and observes writes.
interface imem_loader_if #(
    parameter int ADDR_W = 5
);
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    modport master (
        output byte_valid,
        output byte_data,
        input  byte_ready,
        input  imem_we,
        input  imem_addr,
        input  imem_wdata
    );

    modport slave (
        input  byte_valid,
        input  byte_data,
        output byte_ready,
        output imem_we,
        output imem_addr,
        output imem_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// Program loader for the instruction memory.
// Packs an incoming byte stream MSB-first into 32-bit words, writes them to
// ascending word addresses from 0, then checks a trailing two's-complement
// checksum byte. The CPU is held in reset for the whole load.
module imem_loader #(
    parameter int ADDR_W = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [ADDR_W:0] word_count,
    imem_loader_if.slave    bus,
    output logic            cpu_reset_hold,
    output logic            busy,
    output logic            done,
    output logic            err
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WRITE,
        CHECK,
        DONE
    } state_t;

    // Largest loadable word count is the full memory depth; larger requests
    // are clamped so addresses never wrap.
    localparam logic [ADDR_W:0] MAX_WORDS = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE_WORD  = {{ADDR_W{1'b0}}, 1'b1};

    state_t          state;
    logic [ADDR_W:0] count_q;
    logic [ADDR_W:0] word_idx;
    logic [1:0]      byte_idx;
    logic [7:0]      sum;
    logic [23:0]     wreg;
    logic            accept;
    logic [7:0]      next_sum;

    // A byte moves only when both sides agree; the running sum including the
    // byte on the bus feeds both the LOAD accumulation and the final check.
    assign accept   = bus.byte_valid && bus.byte_ready;
    assign next_sum = sum + bus.byte_data;

    // Loader state machine; every output is a register updated on the
    // transition into the state that owns it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            bus.byte_ready <= 1'b0;
            bus.imem_we    <= 1'b0;
            bus.imem_addr  <= '0;
            bus.imem_wdata <= '0;
            cpu_reset_hold <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            err            <= 1'b0;
            count_q        <= '0;
            word_idx       <= '0;
            byte_idx       <= '0;
            sum            <= '0;
            wreg           <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        count_q        <= (word_count > MAX_WORDS) ? MAX_WORDS : word_count;
                        sum            <= '0;
                        word_idx       <= '0;
                        byte_idx       <= '0;
                        err            <= 1'b0;
                        bus.byte_ready <= 1'b1;
                        busy           <= 1'b1;
                        cpu_reset_hold <= 1'b1;
                        state          <= (word_count == '0) ? CHECK : LOAD;
                    end
                end

                LOAD: begin
                    if (accept) begin
                        sum <= next_sum;
                        if (byte_idx == 2'd3) begin
                            byte_idx       <= '0;
                            bus.byte_ready <= 1'b0;
                            bus.imem_we    <= 1'b1;
                            bus.imem_addr  <= word_idx[ADDR_W-1:0];
                            bus.imem_wdata <= {wreg, bus.byte_data};
                            state          <= WRITE;
                        end else begin
                            byte_idx <= byte_idx + 2'd1;
                            wreg     <= {wreg[15:0], bus.byte_data};
                        end
                    end
                end

                WRITE: begin
                    bus.imem_we    <= 1'b0;
                    bus.byte_ready <= 1'b1;
                    word_idx       <= word_idx + ONE_WORD;
                    state          <= (word_idx == count_q - ONE_WORD) ? CHECK : LOAD;
                end

                CHECK: begin
                    if (accept) begin
                        err            <= (next_sum != 8'd0);
                        bus.byte_ready <= 1'b0;
                        busy           <= 1'b0;
                        done           <= 1'b1;
                        state          <= DONE;
                    end
                end

                DONE: begin
                    done           <= 1'b0;
                    cpu_reset_hold <= 1'b0;
                    state          <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: directed loads push expected writes and
// expected err values; a negedge monitor pops and compares them.
module tb_imem_loader;

    localparam int ADDR_W = 5;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    logic            clk;
    logic            reset;
    logic            start;
    logic [ADDR_W:0] word_count;
    logic            cpu_reset_hold;
    logic            busy;
    logic            done;
    logic            err;

    imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

    imem_loader #(.ADDR_W(ADDR_W)) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .word_count     (word_count),
        .bus            (bus),
        .cpu_reset_hold (cpu_reset_hold),
        .busy           (busy),
        .done           (done),
        .err            (err)
    );

    wr_t  exp_wr[$];
    logic exp_err[$];
    int   check_count = 0;
    int   pass_count  = 0;
    int   we_count    = 0;
    int   done_count  = 0;

    // Free-running clock, 10 time units per period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Monitor: compare every memory write and every done pulse with the scoreboard
    always @(negedge clk) begin
        if (bus.imem_we === 1'b1) begin
            we_count++;
            checkOutput("write_expected", 32'(exp_wr.size() != 0), 32'd1);
            if (exp_wr.size() != 0) begin
                wr_t w;
                w = exp_wr.pop_front();
                checkOutput("write_addr", 32'(bus.imem_addr), 32'(w.addr));
                checkOutput("write_data", bus.imem_wdata, w.data);
            end
        end
        if (done === 1'b1) begin
            done_count++;
            checkOutput("done_expected", 32'(exp_err.size() != 0), 32'd1);
            checkOutput("hold_during_done", 32'(cpu_reset_hold), 32'd1);
            if (exp_err.size() != 0) begin
                logic e;
                e = exp_err.pop_front();
                checkOutput("err_at_done", 32'(err), 32'(e));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one byte and hold it until the loader takes it
    task automatic applyStimulus(input logic [7:0] b, input bit gap);
        int n = 0;
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
        while (bus.byte_ready !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) begin
            checkOutput("byte_ready_timeout", 32'(bus.byte_ready), 32'd1);
        end
        tick();
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'hxx;
        if (gap) begin
            tick();
        end
    endtask

    task automatic startLoad(input logic [ADDR_W:0] n);
        start      = 1'b1;
        word_count = n;
        tick();
        start      = 1'b0;
    endtask

    task automatic waitIdle(input string tag);
        int n = 0;
        while (cpu_reset_hold === 1'b1 && n < 20) begin
            tick();
            n++;
        end
        checkOutput({tag, "_hold_dropped"}, 32'(cpu_reset_hold), 32'd0);
        checkOutput({tag, "_busy_idle"}, 32'(busy), 32'd0);
        checkOutput({tag, "_wr_queue_drained"}, 32'(exp_wr.size()), 32'd0);
        checkOutput({tag, "_err_queue_drained"}, 32'(exp_err.size()), 32'd0);
    endtask

    // Two-word program used by several loads
    task automatic sendBasic(input logic [7:0] csum, input bit gap);
        logic [7:0] prog [8];
        prog = '{8'h20, 8'h10, 8'h00, 8'h0A, 8'h22, 8'h11, 8'h00, 8'h02};
        for (int i = 0; i < 8; i++) begin
            applyStimulus(prog[i], gap);
        end
        applyStimulus(csum, gap);
    endtask

    initial begin
        int         we0;
        int         dn0;
        logic [7:0] s;
        logic [7:0] b;

        reset          = 1'b1;
        start          = 1'b0;
        word_count     = '0;
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;
        repeat (3) tick();
        start = 1'b1;
        word_count = 7'd2;
        tick();
        reset = 1'b0;
        start = 1'b0;

        $display("[TB] reset state");
        checkOutput("rst_byte_ready", 32'(bus.byte_ready), 32'd0);
        checkOutput("rst_imem_we", 32'(bus.imem_we), 32'd0);
        checkOutput("rst_imem_addr", 32'(bus.imem_addr), 32'd0);
        checkOutput("rst_imem_wdata", bus.imem_wdata, 32'd0);
        checkOutput("rst_hold", 32'(cpu_reset_hold), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_err", 32'(err), 32'd0);
        tick();
        checkOutput("start_with_reset_ignored", 32'(busy), 32'd0);

        $display("[TB] load two words, good checksum");
        exp_wr.push_back('{addr: 5'd0, data: 32'h2010000A});
        exp_wr.push_back('{addr: 5'd1, data: 32'h22110002});
        exp_err.push_back(1'b0);
        we0 = we_count;
        dn0 = done_count;
        startLoad(7'd2);
        checkOutput("t1_hold_loading", 32'(cpu_reset_hold), 32'd1);
        checkOutput("t1_busy_loading", 32'(busy), 32'd1);
        sendBasic(8'h91, 1'b0);
        waitIdle("t1");
        checkOutput("t1_we_cycles", 32'(we_count - we0), 32'd2);
        checkOutput("t1_done_pulses", 32'(done_count - dn0), 32'd1);

        $display("[TB] load two words, bad checksum");
        exp_wr.push_back('{addr: 5'd0, data: 32'h2010000A});
        exp_wr.push_back('{addr: 5'd1, data: 32'h22110002});
        exp_err.push_back(1'b1);
        startLoad(7'd2);
        sendBasic(8'h90, 1'b0);
        waitIdle("t2");
        repeat (5) tick();
        checkOutput("t2_err_sticky", 32'(err), 32'd1);

        $display("[TB] load two words, valid on alternate cycles");
        exp_wr.push_back('{addr: 5'd0, data: 32'h2010000A});
        exp_wr.push_back('{addr: 5'd1, data: 32'h22110002});
        exp_err.push_back(1'b0);
        we0 = we_count;
        startLoad(7'd2);
        checkOutput("t3_err_cleared_by_start", 32'(err), 32'd0);
        sendBasic(8'h91, 1'b1);
        waitIdle("t3");
        checkOutput("t3_we_cycles", 32'(we_count - we0), 32'd2);

        $display("[TB] zero-word loads");
        exp_err.push_back(1'b0);
        we0 = we_count;
        startLoad(7'd0);
        applyStimulus(8'h00, 1'b0);
        waitIdle("t4a");
        exp_err.push_back(1'b1);
        startLoad(7'd0);
        applyStimulus(8'h05, 1'b0);
        waitIdle("t4b");
        checkOutput("t4_no_writes", 32'(we_count - we0), 32'd0);

        $display("[TB] reset in the middle of a load");
        exp_wr.push_back('{addr: 5'd0, data: 32'h2010000A});
        we0 = we_count;
        startLoad(7'd2);
        applyStimulus(8'h20, 1'b0);
        applyStimulus(8'h10, 1'b0);
        applyStimulus(8'h00, 1'b0);
        applyStimulus(8'h0A, 1'b0);
        applyStimulus(8'h22, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("t5_byte_ready", 32'(bus.byte_ready), 32'd0);
        checkOutput("t5_hold", 32'(cpu_reset_hold), 32'd0);
        checkOutput("t5_busy", 32'(busy), 32'd0);
        repeat (5) tick();
        checkOutput("t5_one_write", 32'(we_count - we0), 32'd1);
        checkOutput("t5_wr_queue_drained", 32'(exp_wr.size()), 32'd0);

        $display("[TB] oversize load clamps to full memory");
        s = 8'h00;
        for (int i = 0; i < 32; i++) begin
            exp_wr.push_back('{addr: 5'(i),
                               data: {8'(i), 8'(8'h40 + i), 8'(8'h80 + i), 8'(8'hC0 + i)}});
            s = s + 8'(i) + 8'(8'h40 + i) + 8'(8'h80 + i) + 8'(8'hC0 + i);
        end
        exp_err.push_back(1'b0);
        we0 = we_count;
        startLoad(7'd40);
        for (int i = 0; i < 32; i++) begin
            if (i == 10) begin
                startLoad(7'd3);
            end
            applyStimulus(8'(i), 1'b0);
            applyStimulus(8'(8'h40 + i), 1'b0);
            applyStimulus(8'(8'h80 + i), 1'b0);
            applyStimulus(8'(8'hC0 + i), 1'b0);
        end
        b = 8'h00 - s;
        applyStimulus(b, 1'b0);
        waitIdle("t6");
        checkOutput("t6_we_cycles", 32'(we_count - we0), 32'd32);
        checkOutput("t6_last_addr", 32'(bus.imem_addr), 32'd31);

        $display("[TB] %0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
